dmem_responder: RTL

- Data-memory responder serving the core's load/store port: word-organised RAM plus a small MMIO window.
- Accepts the store-width code d_we, the byte address d_addr and store data d_wr_data every cycle.
- Returns read data on d_rd_data one cycle after the address, right-aligned so the load path extracts bytes/halves from the low bits.
- MMIO window holds a console TX FIFO with valid/ready drain port and a free-running 64-bit cycle timer.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/console_fifo.sv | 67 ++++++
 rtl/dmem_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and MMIO map for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_B    = 2'b01,
    ST_H    = 2'b10,
    ST_W    = 2'b11
  } st_width_t;

  localparam logic [15:0] OFS_CONSOLE_TX     = 16'h0000;
  localparam logic [15:0] OFS_CONSOLE_STATUS = 16'h0004;
  localparam logic [15:0] OFS_MTIME_LO       = 16'h0008;
  localparam logic [15:0] OFS_MTIME_HI       = 16'h000C;
  localparam logic [15:0] OFS_MTIMECMP_LO    = 16'h0010;
  localparam logic [15:0] OFS_MTIMECMP_HI    = 16'h0014;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_OVF     = 2;
  localparam int unsigned STAT_CNT_LSB = 8;

  function automatic logic [3:0] lane_mask(input st_width_t w, input logic [1:0] a);
    logic [3:0] m;
    m = '0;
    case (w)
      ST_B:    m = 4'b0001 << a;
      ST_H:    m = a[1] ? 4'b1100 : 4'b0011;
      ST_W:    m = '1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Console TX byte FIFO: push with overflow flag, valid/ready drain, no empty bypass.
module console_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop_ready,
  input  logic                       ovf_clr,
  output logic                       valid,
  output logic [7:0]                 head,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign valid    = !empty;
  assign head     = valid ? mem_q[rd_ptr_q] : '0;
  assign overflow = ovf_q;
  assign count    = count_q;

  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  always_comb begin
    do_pop   = valid && pop_ready;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
    if (ovf_clr)                      ovf_d = 1'b0;
    else if (push && full && !do_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus MMIO console FIFO and 64-bit timer.
// Optional MTIMECMP / timer_irq enabled by macro DMEM_TIMER_CMP_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wr_data,
  output logic [31:0] d_rd_data,
  output logic        misalign_err,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
`ifdef DMEM_TIMER_CMP_EN
  ,
  output logic        timer_irq
`endif
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  st_width_t         we;
  logic              is_mmio, misaligned, store_ok, ram_we, fifo_push, ovf_clr;
  logic [15:0]       ofs;
  logic [IDX_W-1:0]  ram_idx;
  logic [3:0]        be;
  logic [31:0]       wdata_rep, status;
  logic              f_full, f_empty, f_ovf;
  logic [CNT_W-1:0]  f_count;

  logic [31:0] ram_q [DEPTH_WORDS];
  logic [31:0] ram_rd_q, ram_rd_d, mmio_rd_q, mmio_rd_d;
  logic [1:0]  lane_q, lane_d;
  logic        region_q, region_d, misalign_q, misalign_d;
  logic [63:0] mtime_q, mtime_d;

  assign we         = st_width_t'(d_we);
  assign is_mmio    = (d_addr[31:16] == MMIO_BASE[31:16]);
  assign ofs        = {d_addr[15:2], 2'b00};
  assign ram_idx    = d_addr[IDX_W+1:2];
  assign misaligned = ((we == ST_H) && d_addr[0]) || ((we == ST_W) && (d_addr[1:0] != 2'b00));
  assign store_ok   = (we != ST_NONE) && !misaligned;
  assign ram_we     = store_ok && !is_mmio;
  assign be         = lane_mask(we, d_addr[1:0]);
  assign fifo_push  = store_ok && is_mmio && (ofs == OFS_CONSOLE_TX) && ((we == ST_B) || (we == ST_W));
  assign ovf_clr    = store_ok && is_mmio && (ofs == OFS_CONSOLE_STATUS);

  always_comb begin
    wdata_rep = d_wr_data;
    case (we)
      ST_B:    wdata_rep = {4{d_wr_data[7:0]}};
      ST_H:    wdata_rep = {2{d_wr_data[15:0]}};
      default: wdata_rep = d_wr_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) ram_q[ram_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  console_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (d_wr_data[7:0]),
    .pop_ready (tx_ready),
    .ovf_clr   (ovf_clr),
    .valid     (tx_valid),
    .head      (tx_data),
    .full      (f_full),
    .empty     (f_empty),
    .overflow  (f_ovf),
    .count     (f_count)
  );

`ifdef DMEM_TIMER_CMP_EN
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        irq_q, irq_d;
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    irq_d      = (mtime_q >= mtimecmp_q);
    if (is_mmio && (we == ST_W) && !misaligned) begin
      if (ofs == OFS_MTIMECMP_LO) mtimecmp_d[31:0]  = d_wr_data;
      if (ofs == OFS_MTIMECMP_HI) mtimecmp_d[63:32] = d_wr_data;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
    end else begin
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= irq_d;
    end
  end
  assign timer_irq = irq_q;
`endif

  // MMIO read value is captured in the address cycle, so status reflects pre-push state.
  always_comb begin
    status = '0;
    status[STAT_FULL]  = f_full;
    status[STAT_EMPTY] = f_empty;
    status[STAT_OVF]   = f_ovf;
    status[STAT_CNT_LSB +: CNT_W] = f_count;
    mmio_rd_d = '0;
    case (ofs)
      OFS_CONSOLE_STATUS: mmio_rd_d = status;
      OFS_MTIME_LO:       mmio_rd_d = mtime_q[31:0];
      OFS_MTIME_HI:       mmio_rd_d = mtime_q[63:32];
`ifdef DMEM_TIMER_CMP_EN
      OFS_MTIMECMP_LO:    mmio_rd_d = mtimecmp_q[31:0];
      OFS_MTIMECMP_HI:    mmio_rd_d = mtimecmp_q[63:32];
`endif
      default:            mmio_rd_d = '0;
    endcase
    ram_rd_d   = ram_q[ram_idx];
    lane_d     = d_addr[1:0];
    region_d   = is_mmio;
    misalign_d = misaligned;
    mtime_d    = mtime_q + 64'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_rd_q   <= '0;
      mmio_rd_q  <= '0;
      lane_q     <= '0;
      region_q   <= 1'b0;
      misalign_q <= 1'b0;
      mtime_q    <= '0;
    end else begin
      ram_rd_q   <= ram_rd_d;
      mmio_rd_q  <= mmio_rd_d;
      lane_q     <= lane_d;
      region_q   <= region_d;
      misalign_q <= misalign_d;
      mtime_q    <= mtime_d;
    end
  end

  assign d_rd_data    = (region_q ? mmio_rd_q : ram_rd_q) >> {lane_q, 3'b000};
  assign misalign_err = misalign_q;

endmodule
